// File: rtl/logic_fold_unit.sv
// rtl/logic_fold_unit.sv - registered bitwise logic unit with pairwise and fold modes
//
// Applies one of eight bitwise operations to WIDTH-bit operands. In pairwise
// mode each beat yields f(a,b). In fold mode the first beat seeds
// acc = f(a,b), and each later beat updates acc = f(acc,a) until last.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operand beat handshake (in_ready depends on out_ready)
//   op, mode            operation and pairwise/fold select, taken on first beat
//   a, b, last          operands (b first beat only), fold terminator
//   out_valid/out_ready result handshake
//   out, count          registered result and saturating beat count
module logic_fold_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [2:0]       op_q;
  logic             mode_q;

  logic             accept;
  logic [WIDTH-1:0] first_val;
  logic [WIDTH-1:0] fold_val;
  logic [CNT_W-1:0] count_inc;

  // NOT and PASS look only at the second argument, so on a fold's later
  // beats they act on the new operand a rather than on the accumulator.
  function automatic logic [WIDTH-1:0] fop(input logic [2:0] o,
                                           input logic [WIDTH-1:0] x,
                                           input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (o)
      3'd0:    r = ~(x | y);
      3'd1:    r = ~(x & y);
      3'd2:    r = x & y;
      3'd3:    r = x | y;
      3'd4:    r = x ^ y;
      3'd5:    r = ~(x ^ y);
      3'd6:    r = ~y;
      default: r = y;
    endcase
    return r;
  endfunction

  // A held result only blocks new beats when the consumer is not taking it
  // this cycle; that lets OUT overlap the next first beat.
  assign in_ready  = !rst && ((state != S_OUT) || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == S_OUT);

  assign first_val = fop(op, a, b);
  assign fold_val  = fop(op_q, acc, a);
  assign count_inc = (count == {CNT_W{1'b1}}) ? count : count + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      acc    <= '0;
      out    <= '0;
      count  <= '0;
      op_q   <= 3'd0;
      mode_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_OUT: begin
          // In OUT an accept implies out_ready, so the held result has
          // transferred and the beat starts a new result.
          if (accept) begin
            op_q   <= op;
            mode_q <= mode;
            acc    <= first_val;
            count  <= CNT_W'(1);
            if (!mode || last) begin
              out   <= first_val;
              state <= S_OUT;
            end else begin
              state <= S_ACC;
            end
          end else if (state == S_OUT && out_ready) begin
            state <= S_IDLE;
          end
        end
        S_ACC: begin
          if (accept) begin
            acc   <= fold_val;
            count <= count_inc;
            if (last || !mode_q) begin
              out   <= fold_val;
              state <= S_OUT;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_fold_unit.sv
// tb/tb_logic_fold_unit.sv - directed self-checking bench for logic_fold_unit
module tb_logic_fold_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, mode, last, out_valid, out_ready;
  logic [2:0] op;
  logic [7:0] a, b, out;
  logic [3:0] count;

  logic       in_valid2, in_ready2, last2, out_valid2, out_ready2;
  logic [7:0] a2, out2;
  logic [1:0] count2;

  int total = 0;
  int bad   = 0;

  logic [7:0] tp_a [4];
  logic [7:0] tp_b [4];

  always #5 clk = ~clk;

  logic_fold_unit #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .mode(mode), .a(a), .b(b), .last(last),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .count(count)
  );

  logic_fold_unit #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .op(3'd7), .mode(1'b1), .a(a2), .b(8'h01), .last(last2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out(out2), .count(count2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [2:0] o, input logic m, input logic [7:0] va,
                      input logic [7:0] vb, input logic l);
    in_valid = 1'b1; op = o; mode = m; a = va; b = vb; last = l;
    tick();
    in_valid = 1'b0; last = 1'b0;
  endtask

  initial begin
    tp_a[0] = 8'h12; tp_b[0] = 8'h34;
    tp_a[1] = 8'hFF; tp_b[1] = 8'h0F;
    tp_a[2] = 8'hA5; tp_b[2] = 8'hA5;
    tp_a[3] = 8'h00; tp_b[3] = 8'hC3;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 3'd0; mode = 1'b0;
    a = 8'h00; b = 8'h00; last = 1'b0;
    in_valid2 = 1'b0; out_ready2 = 1'b1; a2 = 8'h00; last2 = 1'b0;
    tick(); tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out, 8'h00);
    check("rst_count", count, 0);
    rst = 1'b0; #1;
    check("idle_in_ready", in_ready, 1);

    // pairwise NOR
    beat(3'd0, 1'b0, 8'h0F, 8'h33, 1'b0);
    check("nor_valid", out_valid, 1);
    check("nor_out", out, 8'hC0);
    check("nor_count", count, 1);
    tick();
    check("nor_one_cycle", out_valid, 0);
    check("nor_out_kept", out, 8'hC0);

    // fold AND over 3 beats; op change on beat 2 must be ignored
    beat(3'd2, 1'b1, 8'hFF, 8'hF0, 1'b0);
    check("fold_b1_valid", out_valid, 0);
    check("fold_b1_count", count, 1);
    beat(3'd4, 1'b0, 8'h3C, 8'h00, 1'b0);
    check("fold_b2_valid", out_valid, 0);
    check("fold_b2_count", count, 2);
    beat(3'd4, 1'b0, 8'h3F, 8'h00, 1'b1);
    check("fold_valid", out_valid, 1);
    check("fold_out", out, 8'h30);
    check("fold_count", count, 3);
    tick();
    check("fold_done", out_valid, 0);

    // backpressure
    out_ready = 1'b0;
    beat(3'd0, 1'b0, 8'h0F, 8'h33, 1'b0);
    in_valid = 1'b1; op = 3'd4; mode = 1'b0; a = 8'hAA; b = 8'h55;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_in_ready", in_ready, 0);
      check("bp_valid", out_valid, 1);
      check("bp_out", out, 8'hC0);
      tick();
    end
    out_ready = 1'b1; #1;
    check("bp_release_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("bp_next_valid", out_valid, 1);
    check("bp_next_out", out, 8'hFF);
    check("bp_next_count", count, 1);
    tick();
    check("bp_drain", out_valid, 0);

    // throughput: back-to-back pairwise XOR
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; op = 3'd4; mode = 1'b0; a = tp_a[i]; b = tp_b[i]; #1;
      check("tp_in_ready", in_ready, 1);
      tick();
      check("tp_valid", out_valid, 1);
      check("tp_out", out, tp_a[i] ^ tp_b[i]);
    end
    in_valid = 1'b0;
    tick();
    check("tp_drain", out_valid, 0);

    // reset mid-fold
    beat(3'd3, 1'b1, 8'h01, 8'h02, 1'b0);
    beat(3'd3, 1'b1, 8'h04, 8'h00, 1'b0);
    check("mf_count", count, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mf_rst_valid", out_valid, 0);
    check("mf_rst_out", out, 8'h00);
    check("mf_rst_count", count, 0);
    beat(3'd1, 1'b0, 8'hF0, 8'hFF, 1'b0);
    check("nand_valid", out_valid, 1);
    check("nand_out", out, 8'h0F);
    check("nand_count", count, 1);
    tick();

    // saturation on CNT_W=2 instance: PASS fold of 0x01..0x05
    for (int i = 1; i <= 5; i++) begin
      in_valid2 = 1'b1; a2 = 8'(i); last2 = (i == 5);
      tick();
      if (i == 3) check("sat_count_b3", count2, 3);
      if (i == 4) check("sat_count_b4", count2, 3);
    end
    in_valid2 = 1'b0; last2 = 1'b0;
    check("sat_valid", out_valid2, 1);
    check("sat_out", out2, 8'h05);
    check("sat_count", count2, 3);
    tick();
    check("sat_drain", out_valid2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/logic_fold_unit.md
# logic_fold_unit

Parametrised, registered successor to the team's single-bit switch-level NOR cell. It applies one of eight bitwise logic operations (NOR, NAND, AND, OR, XOR, XNOR, NOT, PASS) to WIDTH-bit operands, either pairwise or folded over a multi-beat operand stream. Valid/ready handshakes on input and output let it sit between stream stages in the logic-lab datapath.

## Interface
- WIDTH, 8: operand and result width in bits.
- CNT_W, 4: beat-counter width; count saturates at 2^CNT_W-1.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  beat accepted when in_valid && in_ready at a clk edge.
- op  input  3  0 NOR, 1 NAND, 2 AND, 3 OR, 4 XOR, 5 XNOR, 6 NOT, 7 PASS; sampled on the first beat only.
- mode  input  1  0 pairwise, 1 fold; sampled on the first beat only.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; used on the first beat only.
- last  input  1  final beat of a fold; ignored in pairwise mode.
- out_valid  output  1  result valid.
- out_ready  input  1  result consumed when out_valid && out_ready.
- out  output  WIDTH  registered result.
- count  output  CNT_W  accepted beats in the current result, saturating.

## Operation
- f(x,y) per op: ~(x|y), ~(x&y), x&y, x|y, x^y, ~(x^y), ~y, y. NOT and PASS use only the second argument.
- States:
  - IDLE: no result is held.
  - ACC: a fold is in progress.
  - OUT: a result is held.
- in_ready is the combinational signal (state != OUT) || out_ready. in_ready is forced to 0 while rst is high.
- IDLE, beat accepted:
  - Latch op and mode.
  - Set acc = f(a,b) and count = 1.
  - If mode=0 or last=1, go to OUT with out = acc. Otherwise go to ACC.
- ACC, beat accepted:
  - Set acc = f(acc,a) with the latched op; b is ignored.
  - count increments and saturates.
  - If last=1, go to OUT with out = acc.
  - The op and mode inputs are ignored in ACC.
- OUT:
  - out_valid = 1. out and count are held stable until the transfer.
  - On a transfer with no simultaneous accepted beat, go to IDLE.
  - On a transfer with a simultaneously accepted beat, handle that beat exactly as an IDLE accept in the same cycle. This gives full throughput.
- ACC with no beat: the block waits indefinitely and holds acc.
- Reset values: state IDLE, out = 0, out_valid = 0, count = 0, acc = 0, latched op/mode = 0. A reset mid-fold or mid-OUT discards everything.
- out_valid is 1 only in OUT. out and count keep their last values after a transfer.

## Timing
- Latency: out_valid rises on the clk edge that accepts the final beat (pairwise beat, or the fold beat with last=1). The result is visible the following cycle.
- Throughput: one pairwise result per cycle while out_ready=1. A fold of N beats takes N cycles plus the OUT cycle, which overlaps the next first beat.
- No combinational path from a, b, op, or mode to out or out_valid. The only combinational path is out_ready -> in_ready.
- rst takes priority over any handshake in the same cycle.

## Test plan
- Pairwise NOR, WIDTH=8: a=0x0F, b=0x33, op=0, mode=0 -> out=0xC0, count=1, out_valid high exactly one cycle with out_ready=1.
- Fold AND over 3 beats:
  - Beats: {a=0xFF, b=0xF0}, {a=0x3C}, {a=0x3F, last=1}, op=2, mode=1.
  - Change op to 4 on beat 2.
  - Required: out=0x30, count=3, and the op change is ignored.
- Backpressure: after the pairwise NOR above, hold out_ready=0 for 5 cycles.
  - Required: out=0xC0 stable, in_ready=0.
  - Then raise out_ready with in_valid=1 and a=0xAA, b=0x55, op=4 in the same cycle. Required: first transfer completes and the next result is out=0xFF.
- Throughput: 4 back-to-back pairwise XOR beats, out_ready=1 throughout -> 4 results on 4 consecutive cycles, in_ready constantly 1.
- Reset mid-fold: 2 OR beats accepted, then rst for 1 cycle.
  - Required: out_valid=0, out=0, count=0.
  - A following pairwise NAND with a=0xF0, b=0xFF gives out=0x0F, unaffected by the discarded fold.
- Saturation: CNT_W=2, 5-beat PASS fold with a=0x01..0x05 -> out=0x05, count=3.
